// File: rtl/gpu_raster_pkg.sv
// Shared raster-pipeline definitions: the line FSM state encoding and the
// default framebuffer geometry used by the framebuffer and triangle blocks.
package gpu_raster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH   = 10;
  localparam int DEF_FB_W    = 640;
  localparam int DEF_FB_H    = 480;
  localparam int DEF_ADDR_W  = 19;
  localparam int DEF_COLOR_W = 6;

endpackage

// File: rtl/bresenham_stepper.sv
// Bresenham walker: load captures the deltas and start point, each step
// moves cur one pixel toward the end point using the error term.
module bresenham_stepper
  import gpu_raster_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] x0_i,
  input  logic [WIDTH-1:0] y0_i,
  input  logic [WIDTH-1:0] x1_i,
  input  logic [WIDTH-1:0] y1_i,
  output logic [WIDTH-1:0] cur_x_o,
  output logic [WIDTH-1:0] cur_y_o,
  output logic             at_end_o
);

  typedef logic signed [WIDTH+1:0] sw_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  sw_t              dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic             sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [WIDTH-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  sw_t              ddx, ddy, abs_dx, neg_dy, e2;

  always_comb begin
    ddx      = $signed({2'b00, x1_i}) - $signed({2'b00, x0_i});
    ddy      = $signed({2'b00, y1_i}) - $signed({2'b00, y0_i});
    abs_dx   = (ddx < 0) ? -ddx : ddx;
    neg_dy   = (ddy < 0) ? ddy : -ddy;
    // |err| never exceeds max(dx,|dy|), so doubling stays inside WIDTH+2 bits
    e2       = err_q <<< 1;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    if (load_i) begin
      dx_d     = abs_dx;
      dy_d     = neg_dy;
      err_d    = abs_dx + neg_dy;
      sx_neg_d = (ddx < 0);
      sy_neg_d = (ddy < 0);
      cur_x_d  = x0_i;
      cur_y_d  = y0_i;
    end else if (step_i) begin
      if (e2 >= dy_q) begin
        err_d   = err_d + dy_q;
        cur_x_d = sx_neg_q ? cur_x_q - ONE : cur_x_q + ONE;
      end
      if (e2 <= dx_q) begin
        err_d   = err_d + dx_q;
        cur_y_d = sy_neg_q ? cur_y_q - ONE : cur_y_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
    end else begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
    end
  end

  assign cur_x_o  = cur_x_q;
  assign cur_y_o  = cur_y_q;
  assign at_end_o = (cur_x_q == x1_i) && (cur_y_q == y1_i);

endmodule

// File: rtl/line_raster_engine.sv
// Line rasteriser top: command capture, IDLE/SETUP/DRAW/DONE sequencing,
// clipping and the registered framebuffer write port.
module line_raster_engine
  import gpu_raster_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FB_W    = DEF_FB_W,
  parameter int FB_H    = DEF_FB_H,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   x0,
  input  logic [WIDTH-1:0]   y0,
  input  logic [WIDTH-1:0]   x1,
  input  logic [WIDTH-1:0]   y1,
  input  logic [COLOR_W-1:0] color_in,
  output logic               busy,
  input  logic               fb_ready,
  output logic               FB_WE,
  output logic [ADDR_W-1:0]  FB_addr,
  output logic [COLOR_W-1:0] color_out,
  output logic               sys_finish,
  output state_e             dbg_state
);

  localparam logic [WIDTH:0] FBW_C = FB_W[WIDTH:0];
  localparam logic [WIDTH:0] FBH_C = FB_H[WIDTH:0];

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               vld_q, vld_d, last_q, last_d, we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               cmd_take, load, step, retire, in_bounds, at_end;
  logic [WIDTH-1:0]   cur_x, cur_y;
  logic [ADDR_W-1:0]  pix_addr;

  bresenham_stepper #(.WIDTH(WIDTH)) u_stepper (
    .clk_i    (clk),
    .rst_ni   (reset),
    .load_i   (load),
    .step_i   (step),
    .x0_i     (x0_q),
    .y0_i     (y0_q),
    .x1_i     (x1_q),
    .y1_i     (y1_q),
    .cur_x_o  (cur_x),
    .cur_y_o  (cur_y),
    .at_end_o (at_end)
  );

  assign in_bounds = ({1'b0, cur_x} < FBW_C) && ({1'b0, cur_y} < FBH_C);
  assign pix_addr  = ADDR_W'(cur_y) * ADDR_W'(FB_W) + ADDR_W'(cur_x);

  // Handshake: a presented pixel with FB_WE=1 is held until fb_ready is
  // seen high; a presented out-of-bounds pixel (FB_WE=0) retires at once.
  always_comb begin
    state_d  = state_q;
    cmd_take = (state_q == ST_IDLE) && start;
    x0_d     = cmd_take ? x0 : x0_q;
    y0_d     = cmd_take ? y0 : y0_q;
    x1_d     = cmd_take ? x1 : x1_q;
    y1_d     = cmd_take ? y1 : y1_q;
    color_d  = cmd_take ? color_in : color_q;
    load     = 1'b0;
    step     = 1'b0;
    vld_d    = vld_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    retire   = vld_q && (!we_q || fb_ready);
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        load    = 1'b1;
        vld_d   = 1'b0;
        we_d    = 1'b0;
        last_d  = 1'b0;
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (retire && last_q) begin
          vld_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else if (!vld_q || retire) begin
          // the stepper runs one pixel ahead of the output register
          vld_d  = 1'b1;
          we_d   = in_bounds;
          addr_d = pix_addr;
          last_d = at_end;
          step   = !at_end;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end

  assign busy       = (state_q == ST_SETUP) || (state_q == ST_DRAW);
  assign sys_finish = (state_q == ST_DONE);
  assign FB_WE      = we_q;
  assign FB_addr    = addr_q;
  assign color_out  = color_q;
  assign dbg_state  = state_q;

endmodule
